// File: rtl/matvec_ctrl.sv
`timescale 1ns/1ps
// Sequencing controller for a fixed-latency matrix-vector multiplier: holds weights,
// issues vectors under a credit limit and buffers each result in an output FIFO.
module matvec_ctrl #(
    parameter int R          = 8,
    parameter int C          = 8,
    parameter int W_X        = 8,
    parameter int W_K        = 8,
    parameter int FIFO_DEPTH = 7,
    localparam int DEPTH     = $clog2(C),
    localparam int W_Y       = W_X + W_K + DEPTH,
    localparam int PIPE      = DEPTH + 2,
    localparam int IF_W      = $clog2(PIPE + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 k_valid,
    output logic                 k_ready,
    input  logic [R*C*W_K-1:0]   k_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [C*W_X-1:0]     x_data,
    output logic [R*C*W_K-1:0]   dp_k,
    output logic [C*W_X-1:0]     dp_x,
    input  logic [R*W_Y-1:0]     dp_y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [R*W_Y-1:0]     y_data,
    output logic                 w_loaded,
    output logic [IF_W-1:0]      inflight
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {NO_W = 1'b0, RUN = 1'b1} state_e;

    state_e               state_q;
    logic                 k_ready_q;
    logic [R*C*W_K-1:0]   dp_k_q;
    logic [C*W_X-1:0]     dp_x_q;
    logic [PIPE-1:0]      vsr_q, vsr_d;
    logic [IF_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [R*W_Y-1:0]     mem_q [FIFO_DEPTH];
    logic [31:0]          credit_used;
    logic                 k_hs, x_hs, push, pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and data stable until that edge, ready never waits on valid.
    assign k_hs = k_valid && k_ready_q;
    assign x_hs = x_valid && x_ready;
    assign push = vsr_q[PIPE-1];
    assign pop  = y_valid && y_ready;

    // Credits: every accepted vector already owns a FIFO slot, so the datapath never stalls.
    assign credit_used = 32'(inflight_q) + 32'(count_q);
    assign x_ready     = (state_q == RUN) && (credit_used < FIFO_DEPTH);

    assign k_ready  = k_ready_q;
    assign w_loaded = (state_q == RUN);
    assign dp_k     = dp_k_q;
    assign dp_x     = dp_x_q;
    assign y_valid  = (count_q != '0);
    assign y_data   = mem_q[rd_ptr_q];
    assign inflight = inflight_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= NO_W;
            k_ready_q <= 1'b0;
            dp_k_q    <= '0;
        end else begin
            k_ready_q <= 1'b1;
            if (k_hs) dp_k_q <= k_data;
            case (state_q)
                NO_W:    if (k_hs) state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= NO_W;
            endcase
        end
    end

    always_comb begin
        vsr_d      = {vsr_q[PIPE-2:0], x_hs};
        inflight_d = inflight_q;
        if (x_hs && !push)      inflight_d = inflight_q + IF_W'(1);
        else if (!x_hs && push) inflight_d = inflight_q - IF_W'(1);
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_x_q     <= '0;
            vsr_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (x_hs) dp_x_q <= x_data;
            vsr_q      <= vsr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is not reset; the cleared count keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dp_y;
    end
endmodule

// File: doc/matvec_ctrl.md
Name: matvec_ctrl

Overview:
- Sequencing controller wrapped around the pipelined matrix-vector multiplier (adder-tree datapath, no stall input, fixed latency).
- Holds the weight matrix, accepts input vectors on a valid/ready stream and issues them into the datapath.
- Tracks in-flight results with a valid shift register and captures each result into an output FIFO.
- Uses credit-based issue control so the free-running datapath never produces a result with no FIFO slot to hold it.

Parameters:
- R, 8, matrix rows / output vector length
- C, 8, matrix columns / input vector length (power of two)
- W_X, 8, input vector element width (signed)
- W_K, 8, weight element width (signed)
- FIFO_DEPTH, 7, output FIFO entries; minimum 1; sustained 1 vector/cycle requires FIFO_DEPTH >= DEPTH+4
- localparam DEPTH = $clog2(C); W_Y = W_X+W_K+DEPTH; PIPE = DEPTH+2 (cycles from accept to FIFO write)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- k_valid  in  1  weight-load request
- k_ready  out  1  weight-load accept
- k_data  in  R*C*W_K  signed weight matrix [R][C]
- x_valid  in  1  input vector valid
- x_ready  out  1  input vector accept
- x_data  in  C*W_X  signed input vector [C]
- dp_k  out  R*C*W_K  registered weights to datapath
- dp_x  out  C*W_X  registered vector to datapath
- dp_y  in  R*W_Y  datapath result
- y_valid  out  1  output FIFO non-empty
- y_ready  in  1  consumer accept
- y_data  out  R*W_Y  FIFO head
- w_loaded  out  1  weights valid (FSM in RUN)
- inflight  out  $clog2(PIPE+1)  accepted vectors not yet written to FIFO

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM to NO_W; dp_k, dp_x, valid shift register, inflight, FIFO pointers and count cleared to 0.
  - k_ready=0, x_ready=0, y_valid=0, w_loaded=0 while rstn is low.
  - Reset mid-operation discards all in-flight and buffered results; no late y_valid after release.
- FSM:
  - NO_W: k_ready=1, x_ready=0. A k handshake loads dp_k and moves to RUN.
  - RUN: k_ready=1. No other transitions; only reset returns to NO_W.
- Weight load: dp_k updates at the handshake edge.
  - If a k and an x handshake land on the same edge, that x uses the new weights.
  - Vectors accepted earlier use the old weights; already-issued vectors are never corrupted.
- Issue:
  - x_ready = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH).
  - x_ready depends on registered state only; there is no combinational y_ready->x_ready path.
  - On an x handshake at edge t: dp_x <= x_data at t, and a 1 enters the PIPE-long valid shift register.
  - The datapath product is registered at t+1 and dp_y is stable after edge t+DEPTH+1.
  - FIFO write happens at edge t+PIPE, when the shift register tail is 1.
  - dp_x holds its last value when there is no issue. Bubbles shift 0.
- inflight: +1 on issue, -1 on FIFO write; both on the same edge leaves it unchanged.
- FIFO:
  - Circular buffer, pointers wrap at FIFO_DEPTH. y_valid = count>0; y_data = head entry, registered.
  - Pop on y_valid && y_ready. Push and pop on the same edge leave count unchanged.
  - Overflow is impossible by the credit rule. The bench asserts that no push ever occurs when count==FIFO_DEPTH.
  - A pop at edge e frees its credit for issue in cycle e+1.
- Arithmetic: product and sums are signed W_Y, full precision, no saturation.
- Ordering: results leave in strict accept order.

Test Plan:
- Reset, drive x_valid=1 without weights -> x_ready=0 and y_valid=0 indefinitely; w_loaded=0.
- Load identity weights (k[r][c]=(r==c)), issue x=[1,-2,3,-4,5,-6,7,-8] -> y_data equals x sign-extended to W_Y exactly PIPE=5 edges after accept; inflight returns to 0.
- Load all-ones weights, stream 20 vectors back-to-back with y_ready=1 -> one accept per cycle after the first, 20 results in order. For x all elements=-128 with k all=-128, y[r]=131072.
- Hold y_ready=0 and keep x_valid=1 -> exactly 7 accepts, then x_ready=0. FIFO count ends at 7 with no overflow. Release y_ready -> all 7 drain in order, then issue resumes.
- Same-edge k and x handshake (k switches all-ones to all-twos, x all=1) -> that result is 16 per row. The vector accepted one cycle earlier yields 8.
- Assert rstn low with 3 in flight and 2 buffered -> y_valid=0 immediately. After release: NO_W, inflight=0, and no stale results ever emitted.
